scan_ctrl_chain: RTL and testbench
==================================

Name: scan_ctrl_chain

Overview:
- Parametrised serial-load control register. Generalises the fixed per-bit daisy-chained digital control registers into one WIDTH-bit scan chain.
- Adds a shadow/update stage, so control outputs change only on a validated update. Adds a capture path for readback through the serial output.
- Adds shift-length checking and sticky error status.
- Sits between the chip's serial configuration pins (dataIn/dataOut/clk) and the analog/mixed-signal control inputs (DSR, mux selects, enables).

Parameters:
- WIDTH, 32: number of control bits in the chain and on ctrl_out. Legal range 2..256.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into the chain and ctrl_out on reset.
- DUMMY_STAGES, 1: retiming flops between chain bit 0 and dataOut. Legal range 0..4.

Ports:
- clk  input  1  configuration clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- shift_en  input  1  when high, the chain and dummy stages shift one position this cycle.
- dataIn  input  1  serial data in; enters chain bit WIDTH-1.
- dataOut  output  1  serial data out, taken from the last dummy stage (or chain[0] if DUMMY_STAGES=0).
- update  input  1  single-cycle strobe: transfer chain to ctrl_out if the length is valid.
- capture  input  1  single-cycle strobe: load ctrl_out into the chain for readback.
- err_clr  input  1  clears err_status.
- ctrl_out  output  WIDTH  registered control word driving the analog blocks.
- update_done  output  1  one-cycle pulse, the cycle after a successful update.
- err_status  output  2  sticky error flags: bit0 = length error, bit1 = command collision.

Behaviour:
- Reset (reset=0, asynchronous):
  - chain and ctrl_out = RESET_VALUE; dummy stages = 0.
  - shift_cnt = 0; update_done = 0; err_status = 2'b00.
  - Reset mid-shift discards all partial data.
  - Outputs hold their reset values until the first rising clk edge after reset deasserts.
- Shift (shift_en=1):
  - chain <= {dataIn, chain[WIDTH-1:1]}.
  - dummy[0] <= chain[0]; dummy[i] <= dummy[i-1].
  - Dummy stages hold when shift_en=0.
  - Ordering: the first bit shifted lands in chain[0] after WIDTH shifts, so a word shifted LSB-first lands as-is.
  - Readback latency: after capture, dataOut shows chain bit k after k+DUMMY_STAGES shift edges. With DUMMY_STAGES=0, dataOut = chain[0] combinationally.
- shift_cnt:
  - Counts shift cycles since the last update, capture or reset.
  - Saturates at WIDTH+1, which means overlength. Width is clog2(WIDTH+2).
- Update (update=1, shift_en=0):
  - If shift_cnt == WIDTH: ctrl_out <= chain, and update_done is 1 in the next cycle only.
  - Otherwise: ctrl_out is unchanged and err_status[0] is set.
  - shift_cnt clears to 0 in both cases. The chain is unchanged.
- Capture (capture=1, shift_en=0, update=0): chain <= ctrl_out; shift_cnt <= 0; ctrl_out unchanged.
- Collisions (each sets err_status[1]):
  - shift_en with update or capture: only the shift is performed; the strobes are ignored and shift_cnt still increments.
  - update and capture together (no shift): update is evaluated normally; capture is ignored.
- err_clr:
  - Clears err_status at the next edge.
  - If a new error is detected in the same cycle, the set wins for that bit.
- No output is combinational from inputs except dataOut when DUMMY_STAGES=0. ctrl_out glitch-free (direct flop outputs).

Test Plan:
- WIDTH=8, DUMMY_STAGES=1; after reset: ctrl_out=0x00, dataOut=0, err_status=00, update_done=0.
- Shift 0xA5 LSB-first (8 cycles), then update -> ctrl_out=0xA5 on the following edge; update_done high exactly 1 cycle; err_status=00.
- Shift 7 bits of 0xFF, then update -> ctrl_out stays 0xA5; err_status=01; update_done stays 0. Then err_clr -> err_status=00. Then shift 10 bits and update -> err_status=01 (overlength).
- Readback:
  - Setup: ctrl_out=0xA5, then capture, then shift 9 cycles with dataIn=0.
  - Expected dataOut after edges 1..8: 1,0,1,0,0,1,0,1.
  - ctrl_out unchanged throughout.
- Collisions: assert update with shift_en=1 -> err_status[1]=1, ctrl_out unchanged, shift_cnt incremented. Assert update+capture with valid count -> ctrl_out updated, chain not reloaded, err_status[1]=1.
- Mid-shift reset: shift 4 bits, pulse reset low asynchronously between edges -> ctrl_out=RESET_VALUE immediately. Subsequent full 8-bit shift of 0x3C plus update -> ctrl_out=0x3C.

Source files
------------

// File: rtl/scan_ctrl_chain.sv
// scan_ctrl_chain
//   Serial-load control register for analog/mixed-signal blocks. A WIDTH-bit
//   scan chain is shifted in from dataIn. An update strobe copies it to the
//   ctrl_out shadow register, but only when exactly WIDTH bits were shifted.
//   A capture strobe reloads the chain from ctrl_out, so the current setting
//   can be read back on dataOut. Length and command-collision errors are
//   kept in sticky status flags.
//
// Ports
//   clk          configuration clock, rising edge
//   reset        asynchronous active-low reset
//   shift_en     shift chain and dummy stages one position
//   dataIn       serial in, enters chain[WIDTH-1]
//   dataOut      serial out, from last dummy stage (chain[0] if none)
//   update       strobe: chain -> ctrl_out when the length is valid
//   capture      strobe: ctrl_out -> chain for readback
//   err_clr      clear err_status
//   ctrl_out     registered control word
//   update_done  one-cycle pulse after a successful update
//   err_status   sticky flags: [0] length error, [1] command collision
module scan_ctrl_chain #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
    parameter int               DUMMY_STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             dataIn,
    output logic             dataOut,
    input  logic             update,
    input  logic             capture,
    input  logic             err_clr,
    output logic [WIDTH-1:0] ctrl_out,
    output logic             update_done,
    output logic [1:0]       err_status
);

    localparam int             CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    // Terminal value: anything beyond WIDTH shifts is simply "overlength".
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] chain;
    logic [CNT_W-1:0] shift_cnt;
    logic             len_err;
    logic             col_err;

    // Length error only when the update is actually evaluated (no shift).
    assign len_err = update && !shift_en && (shift_cnt != CNT_FULL);
    assign col_err = (shift_en && (update || capture)) || (update && capture);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain       <= RESET_VALUE;
            ctrl_out    <= RESET_VALUE;
            shift_cnt   <= '0;
            update_done <= 1'b0;
            err_status  <= 2'b00;
        end else begin
            update_done <= 1'b0;
            if (shift_en) begin
                chain <= {dataIn, chain[WIDTH-1:1]};
                if (shift_cnt != CNT_SAT) begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end else if (update) begin
                // Capture asserted alongside update is ignored here.
                if (shift_cnt == CNT_FULL) begin
                    ctrl_out    <= chain;
                    update_done <= 1'b1;
                end
                shift_cnt <= '0;
            end else if (capture) begin
                chain     <= ctrl_out;
                shift_cnt <= '0;
            end
            // A newly detected error wins over a simultaneous clear.
            if (err_clr) begin
                err_status <= {col_err, len_err};
            end else begin
                err_status <= err_status | {col_err, len_err};
            end
        end
    end

    generate
        if (DUMMY_STAGES == 0) begin : g_no_dummy
            assign dataOut = chain[0];
        end else begin : g_dummy
            logic [DUMMY_STAGES-1:0] dummy;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dummy <= '0;
                end else if (shift_en) begin
                    dummy[0] <= chain[0];
                    for (int i = 1; i < DUMMY_STAGES; i++) begin
                        dummy[i] <= dummy[i-1];
                    end
                end
            end

            assign dataOut = dummy[DUMMY_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_scan_ctrl_chain.sv
// tb_scan_ctrl_chain
//   Directed bench for scan_ctrl_chain with WIDTH=8, DUMMY_STAGES=1.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_scan_ctrl_chain;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         shift_en;
    logic         dataIn;
    logic         dataOut;
    logic         update;
    logic         capture;
    logic         err_clr;
    logic [W-1:0] ctrl_out;
    logic         update_done;
    logic [1:0]   err_status;

    int n_checks = 0;
    int n_fail   = 0;

    scan_ctrl_chain #(
        .WIDTH        (W),
        .RESET_VALUE  ({W{1'b0}}),
        .DUMMY_STAGES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .shift_en    (shift_en),
        .dataIn      (dataIn),
        .dataOut     (dataOut),
        .update      (update),
        .capture     (capture),
        .err_clr     (err_clr),
        .ctrl_out    (ctrl_out),
        .update_done (update_done),
        .err_status  (err_status)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift n bits of w, LSB first.
    task automatic shift_word(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            dataIn   = w[i];
            shift_en = 1'b1;
            tick();
        end
        shift_en = 1'b0;
        dataIn   = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    logic [7:0] rb_exp;
    logic [7:0] c3_bits;

    initial begin
        reset    = 1'b0;
        shift_en = 1'b0;
        dataIn   = 1'b0;
        update   = 1'b0;
        capture  = 1'b0;
        err_clr  = 1'b0;
        tick();
        tick();
        check_val("rst_ctrl_out", 32'(ctrl_out), 32'h00);
        check_val("rst_dataOut", 32'(dataOut), 32'h0);
        check_val("rst_err", 32'(err_status), 32'h0);
        check_val("rst_update_done", 32'(update_done), 32'h0);
        #3 reset = 1'b1;
        tick();

        // Valid 8-bit load.
        shift_word(16'h00A5, 8);
        check_val("pre_update_ctrl", 32'(ctrl_out), 32'h00);
        pulse_update();
        check_val("upd_ctrl_out", 32'(ctrl_out), 32'hA5);
        check_val("upd_done_hi", 32'(update_done), 32'h1);
        check_val("upd_err", 32'(err_status), 32'h0);
        tick();
        check_val("upd_done_lo", 32'(update_done), 32'h0);

        // Short shift: rejected.
        shift_word(16'h00FF, 7);
        pulse_update();
        check_val("short_ctrl", 32'(ctrl_out), 32'hA5);
        check_val("short_err", 32'(err_status), 32'h1);
        check_val("short_done", 32'(update_done), 32'h0);
        pulse_err_clr();
        check_val("clr_err", 32'(err_status), 32'h0);

        // Overlength shift: rejected.
        shift_word(16'h03FF, 10);
        pulse_update();
        check_val("long_ctrl", 32'(ctrl_out), 32'hA5);
        check_val("long_err", 32'(err_status), 32'h1);
        check_val("long_done", 32'(update_done), 32'h0);
        pulse_err_clr();
        check_val("clr_err2", 32'(err_status), 32'h0);

        // Readback of 0xA5.
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check_val("cap_ctrl", 32'(ctrl_out), 32'hA5);
        rb_exp = 8'hA5;
        for (int k = 0; k < 9; k++) begin
            dataIn   = 1'b0;
            shift_en = 1'b1;
            tick();
            if (k < 8) begin
                check_val($sformatf("rb_bit%0d", k), 32'(dataOut), 32'(rb_exp[k]));
            end
            check_val($sformatf("rb_ctrl%0d", k), 32'(ctrl_out), 32'hA5);
        end
        shift_en = 1'b0;
        check_val("rb_err", 32'(err_status), 32'h0);

        // Update during the 8th shift: shift wins, count still increments.
        capture = 1'b1;           // reset count via capture first
        tick();
        capture = 1'b0;
        shift_word(16'h005A, 7);
        dataIn   = 1'b0;          // bit 7 of 0x5A
        shift_en = 1'b1;
        update   = 1'b1;
        tick();
        shift_en = 1'b0;
        update   = 1'b0;
        check_val("col_shift_ctrl", 32'(ctrl_out), 32'hA5);
        check_val("col_shift_err", 32'(err_status), 32'h2);
        check_val("col_shift_done", 32'(update_done), 32'h0);
        pulse_err_clr();
        pulse_update();
        check_val("col_cnt_ctrl", 32'(ctrl_out), 32'h5A);
        check_val("col_cnt_err", 32'(err_status), 32'h0);

        // Update + capture with valid count: update wins, no reload.
        shift_word(16'h00C3, 8);
        update  = 1'b1;
        capture = 1'b1;
        tick();
        update  = 1'b0;
        capture = 1'b0;
        check_val("uc_ctrl", 32'(ctrl_out), 32'hC3);
        check_val("uc_err", 32'(err_status), 32'h2);
        check_val("uc_done", 32'(update_done), 32'h1);
        c3_bits = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            dataIn   = 1'b0;
            shift_en = 1'b1;
            tick();
            check_val($sformatf("uc_chain_bit%0d", k), 32'(dataOut), 32'(c3_bits[k]));
        end
        dataIn   = 1'b0;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;

        // Clear together with a new length error: new error wins, old collision cleared.
        err_clr = 1'b1;
        update  = 1'b1;
        tick();
        err_clr = 1'b0;
        update  = 1'b0;
        check_val("clr_vs_set", 32'(err_status), 32'h1);
        check_val("clr_vs_set_ctrl", 32'(ctrl_out), 32'hC3);

        // Asynchronous reset mid-shift.
        shift_word(16'h000F, 4);
        #3 reset = 1'b0;
        #1;
        check_val("async_rst_ctrl", 32'(ctrl_out), 32'h00);
        check_val("async_rst_err", 32'(err_status), 32'h0);
        check_val("async_rst_dout", 32'(dataOut), 32'h0);
        #1 reset = 1'b1;
        tick();
        shift_word(16'h003C, 8);
        pulse_update();
        check_val("post_rst_ctrl", 32'(ctrl_out), 32'h3C);
        check_val("post_rst_done", 32'(update_done), 32'h1);
        check_val("post_rst_err", 32'(err_status), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
